// File: rtl/serial_add_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 2-bit ripple slice per clock, carry held
// between slices, operands in and result out over valid/ready handshakes.
module serial_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(WIDTH / 2 - 1);

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               s0_s, s1_s, c1_s, c2_s;
  logic [WIDTH+1:0]   acc_ext_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Slice arithmetic, next-state and registered output decodes
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    s0_s      = a_q[0] ^ b_q[0] ^ carry_q;
    c1_s      = maj(a_q[0], b_q[0], carry_q);
    s1_s      = a_q[1] ^ b_q[1] ^ c1_s;
    c2_s      = maj(a_q[1], b_q[1], c1_s);
    // New slice enters at the top so the first slice lands at [1:0] when done
    acc_ext_s = {s1_s, s0_s, acc_q};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          cnt_d      = '0;
          acc_d      = '0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_ext_s[WIDTH+1:2];
        a_d     = a_q >> 2'd2;
        b_d     = b_q >> 2'd2;
        carry_d = c2_s;
        if (cnt_q == LAST_SLICE) begin
          sum_d       = acc_ext_s[WIDTH+1:2];
          cout_d      = c2_s;
          ovf_d       = c1_s ^ c2_s;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and random checks of serial_add_sequencer at WIDTH=2, 8 and 16.
module tb_serial_add_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, cin8 = 1'b0, co8, of8, bz8;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00, s8;
  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, cin16 = 1'b0, co16, of16, bz16;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000, s16;
  logic        iv2 = 1'b0, ir2, ov2, or2 = 1'b0, cin2 = 1'b0, co2, of2, bz2;
  logic [1:0]  a2 = 2'b00, b2 = 2'b00, s2;

  serial_add_sequencer #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8),
    .ovf(of8), .busy(bz8));
  serial_add_sequencer #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16),
    .ovf(of16), .busy(bz16));
  serial_add_sequencer #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(cin2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2),
    .ovf(of2), .busy(bz2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the 8-bit DUT idle; leaves it idle at a negedge.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int n;
    check({tag, "_rdy"}, ir8, 1);
    a8 = ta; b8 = tb_; cin8 = tc; iv8 = 1'b1;
    @(negedge clk); iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n - 1, 4);
    check({tag, "_sum"}, s8, es);
    check({tag, "_cout"}, co8, ec);
    check({tag, "_ovf"}, of8, eo);
    or8 = 1'b1; @(negedge clk); or8 = 1'b0;
    check({tag, "_idle"}, {ir8, ov8, bz8}, 3'b100);
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       input logic [15:0] es, input logic ec, input logic eo, input string tag);
    int n;
    check({tag, "_rdy"}, ir16, 1);
    a16 = ta; b16 = tb_; cin16 = tc; iv16 = 1'b1;
    @(negedge clk); iv16 = 1'b0;
    n = 1;
    while (!ov16 && n < 30) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n - 1, 8);
    check({tag, "_sum"}, s16, es);
    check({tag, "_cout"}, co16, ec);
    check({tag, "_ovf"}, of16, eo);
    or16 = 1'b1; @(negedge clk); or16 = 1'b0;
    check({tag, "_idle"}, {ir16, ov16, bz16}, 3'b100);
  endtask

  task automatic run2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc,
                      input logic [1:0] es, input logic ec, input logic eo, input string tag);
    int n;
    a2 = ta; b2 = tb_; cin2 = tc; iv2 = 1'b1;
    @(negedge clk); iv2 = 1'b0;
    n = 1;
    while (!ov2 && n < 10) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n - 1, 1);
    check({tag, "_sum"}, s2, es);
    check({tag, "_cout"}, co2, ec);
    check({tag, "_ovf"}, of2, eo);
    or2 = 1'b1; @(negedge clk); or2 = 1'b0;
    check({tag, "_idle"}, {ir2, ov2, bz2}, 3'b100);
  endtask

  initial begin
    logic [7:0]  ra8, rb8, es8;
    logic [15:0] ra16, rb16, es16;
    logic        rc, ec;
    int          n;

    #12;
    check("rst_w8", {ir8, ov8, bz8, s8, co8, of8}, {3'b100, 8'h00, 2'b00});
    check("rst_w16", {ir16, ov16, bz16, s16, co16, of16}, {3'b100, 16'h0000, 2'b00});
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "add_3c_0f");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "add_cin");
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");

    // Back-pressure: result must hold while out_ready stays low
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; iv8 = 1'b1;
    @(negedge clk); iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {ov8, ir8, bz8, s8, co8, of8}, {3'b101, 8'h00, 2'b11});
      @(negedge clk);
    end
    or8 = 1'b1; @(negedge clk); or8 = 1'b0;
    check("bp_release", {ir8, ov8, bz8}, 3'b100);

    // Overlap: second operand set presented during RUN/DONE must wait
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h41;
    n = 1;
    while (!ov8 && n < 20) begin @(negedge clk); n++; end
    check("ovl_first", {s8, co8, of8}, {8'h33, 2'b00});
    or8 = 1'b1; @(negedge clk); or8 = 1'b0;
    check("ovl_no_accept", {ir8, ov8, bz8}, 3'b100);
    @(negedge clk); iv8 = 1'b0;
    check("ovl_accept", {ir8, bz8}, 2'b01);
    n = 1;
    while (!ov8 && n < 20) begin @(negedge clk); n++; end
    check("ovl_second", {s8, co8, of8}, {8'h81, 2'b01});
    or8 = 1'b1; @(negedge clk); or8 = 1'b0;

    // Asynchronous reset in the middle of an operation
    a8 = 8'hAB; b8 = 8'h01; cin8 = 1'b0; iv8 = 1'b1;
    @(negedge clk); iv8 = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", {ov8, s8, bz8, ir8, co8, of8}, {1'b0, 8'h00, 4'b0100});
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "after_rst");

    run2(2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, "w2_a");
    run2(2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 1'b1, "w2_b");

    run16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "w16_ovf");
    run16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "w16_wrap");

    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom);
      {ec, es8} = {1'b0, ra8} + {1'b0, rb8} + {8'h00, rc};
      run8(ra8, rb8, rc, es8, ec, (ra8[7] == rb8[7]) && (es8[7] != ra8[7]), "rand8");
    end
    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rc = 1'($urandom);
      {ec, es16} = {1'b0, ra16} + {1'b0, rb16} + {16'h0000, rc};
      run16(ra16, rb16, rc, es16, ec, (ra16[15] == rb16[15]) && (es16[15] != ra16[15]), "rand16");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
